// File: rtl/sprite_reg_pkg.sv
// Shared types and slave register map for the sprite register master.
// State encoding and the display peripheral's position register addresses.
package sprite_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WRITE
    } state_e;

    // Slave register map of the display peripheral
    localparam int DINO_X = 0;
    localparam int DINO_Y = 1;
    localparam int JUMP_X = 2;
    localparam int JUMP_Y = 3;
    localparam int DUCK_X = 4;
    localparam int DUCK_Y = 5;
    localparam int SCAC_X = 6;
    localparam int SCAC_Y = 7;
    localparam int GODZ_X = 8;
    localparam int GODZ_Y = 9;

endpackage

// File: rtl/lowest_set_idx.sv
// Priority encoder: reports whether any mask bit is set and the index
// of the lowest set bit.
module lowest_set_idx #(
    parameter int N  = 10,
    parameter int IW = 4
) (
    input  logic [N-1:0]  mask_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    // Scan high to low so the lowest set bit is written last and wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                found_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/sprite_reg_master.sv
// Shadows sprite position registers and flushes the dirty ones to the
// display peripheral over Avalon-MM at each vertical-sync start.
module sprite_reg_master
    import sprite_reg_pkg::*;
#(
    parameter int NUM_REGS = 10,
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 8,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vga_vs,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic [DATA_W-1:0] upd_data,
    output logic [ADDR_W-1:0] av_address,
    output logic [31:0]       av_writedata,
    output logic              av_write,
    output logic              av_chipselect,
    input  logic              av_waitrequest,
    output logic              busy,
    output logic [7:0]        overrun_cnt
);

    state_e state_q, state_d;

    logic [DATA_W-1:0]   shadow_q [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q, dirty_d;
    logic [NUM_REGS-1:0] snap_q, snap_d;
    logic                vs_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                write_q, write_d;
    logic                cs_q, cs_d;
    logic                busy_q, busy_d;
    logic [7:0]          ovr_q, ovr_d;

    logic             fs;
    logic             upd_hit;
    logic             found;
    logic [IDX_W-1:0] low_idx;

    assign fs      = vs_q & ~vga_vs;
    assign upd_hit = upd_valid && ({1'b0, upd_idx} < (IDX_W + 1)'(NUM_REGS));

    lowest_set_idx #(
        .N  (NUM_REGS),
        .IW (IDX_W)
    ) u_enc (
        .mask_i  (snap_q),
        .found_o (found),
        .idx_o   (low_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (upd_hit) begin
            shadow_q[upd_idx] <= upd_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dirty_q <= '0;
            snap_q  <= '0;
            vs_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            dirty_q <= dirty_d;
            snap_q  <= snap_d;
            vs_q    <= vga_vs;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dirty_d = dirty_q;
        snap_d  = snap_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        cs_d    = cs_q;
        busy_d  = busy_q;
        ovr_d   = ovr_q;

        // A frame start during a flush is only counted, never restarts it.
        if (fs && state_q != IDLE && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (fs) begin
                    snap_d  = dirty_q;
                    dirty_d = '0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!found) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    addr_d          = ADDR_W'(low_idx);
                    wdata_d         = 32'(shadow_q[low_idx]);
                    write_d         = 1'b1;
                    cs_d            = 1'b1;
                    snap_d[low_idx] = 1'b0;
                    state_d         = WRITE;
                end
            end
            WRITE: begin
                if (!av_waitrequest) begin
                    write_d = 1'b0;
                    cs_d    = 1'b0;
                    state_d = SCAN;
                end
            end
            default: state_d = IDLE;
        endcase

        // A same-cycle update must survive the frame-start clear.
        if (upd_hit) begin
            dirty_d[upd_idx] = 1'b1;
        end
    end

    assign av_address    = addr_q;
    assign av_writedata  = wdata_q;
    assign av_write      = write_q;
    assign av_chipselect = cs_q;
    assign busy          = busy_q;
    assign overrun_cnt   = ovr_q;

endmodule
